// File: rtl/currctrl_gpio_master.sv
// currctrl_gpio_master
//
// Avalon-MM initiator for the CurrCTRL GPIO register slave. It turns a
// valid/ready command stream into single-cycle bus accesses: write, set-bits,
// clear-bits and read. A free-running timer also schedules a periodic poll of
// the slave's edge-capture register. A non-zero capture is cleared and reported
// on the evt_* outputs together with the input level.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   cmd_valid/ready       command handshake
//   cmd_op, cmd_data      0 write data_out, 1 set bits, 2 clear bits, 3 read
//   rsp_valid, rsp_data   read result pulse; data held until the next pulse
//   evt_valid, evt_mask,  captured falling edges and the input level read
//   evt_level             after the clear; mask/level held
//   busy                  FSM not in IDLE
//   avm_*                 Avalon-MM initiator; readdata arrives one cycle after
//                         the address cycle, and there is no waitrequest
//
// Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
// are both high. cmd_ready is high only in IDLE with no poll pending. The
// offered command must hold until it transfers.
//
// Bus strobes and the capture pulses are decoded from the registered state.
// This lets EC_CAP start the clear write in the cycle the capture value
// arrives. It also lets RD_CAP/LV_CAP present read data in the cycle it
// arrives. An asynchronous reset therefore idles the bus immediately.

module currctrl_gpio_master #(
    parameter int POLL_DIV = 1000,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              evt_valid,
    output logic [DATA_W-1:0] evt_mask,
    output logic [DATA_W-1:0] evt_level,
    output logic              busy,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata
);

    localparam int                CNT_W   = $clog2(POLL_DIV);
    localparam logic [CNT_W-1:0]  RELOAD  = CNT_W'(POLL_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_EDGE = 3'd3;
    localparam logic [2:0] A_SET  = 3'd4;
    localparam logic [2:0] A_CLR  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_RD_CAP, S_EC_RD, S_EC_CAP, S_LV_RD, S_LV_CAP
    } state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] ec_q;
    logic [DATA_W-1:0] rsp_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] level_q;
    logic [CNT_W-1:0]  cnt;
    logic              poll_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= '0;
            data_q    <= '0;
            ec_q      <= '0;
            rsp_q     <= '0;
            mask_q    <= '0;
            level_q   <= '0;
            cnt       <= RELOAD;
            poll_pend <= 1'b0;
        end else begin
            if (cnt == '0) begin
                cnt <= RELOAD;
            end else begin
                cnt <= cnt - CNT_ONE;
            end
            // Registering the tick one count early makes poll_pend visible in
            // the cycle the counter reads zero. A tick while pending coalesces.
            if (cnt == CNT_ONE) begin
                poll_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (poll_pend) begin
                        state     <= S_EC_RD;
                        poll_pend <= 1'b0;
                    end else if (cmd_valid) begin
                        op_q   <= cmd_op;
                        data_q <= cmd_data;
                        state  <= (cmd_op == 2'd3) ? S_RD : S_WR;
                    end
                end
                S_WR:     state <= S_IDLE;
                S_RD:     state <= S_RD_CAP;
                S_RD_CAP: begin
                    rsp_q <= avm_readdata;
                    state <= S_IDLE;
                end
                S_EC_RD:  state <= S_EC_CAP;
                S_EC_CAP: begin
                    ec_q  <= avm_readdata;
                    state <= (avm_readdata != '0) ? S_LV_RD : S_IDLE;
                end
                S_LV_RD:  state <= S_LV_CAP;
                S_LV_CAP: begin
                    mask_q  <= ec_q;
                    level_q <= avm_readdata;
                    state   <= S_IDLE;
                end
                default:  state <= S_IDLE;
            endcase
        end
    end

    // The reset term keeps cmd_ready low while reset is held.
    assign cmd_ready = (state == S_IDLE) && !poll_pend && !reset;
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RD_CAP);
    assign rsp_data  = rsp_valid ? avm_readdata : rsp_q;
    assign evt_valid = (state == S_LV_CAP);
    assign evt_mask  = evt_valid ? ec_q : mask_q;
    assign evt_level = evt_valid ? avm_readdata : level_q;

    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = A_DATA;
        avm_writedata  = '0;
        case (state)
            S_WR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_writedata  = data_q;
                case (op_q)
                    2'd1:    avm_address = A_SET;
                    2'd2:    avm_address = A_CLR;
                    default: avm_address = A_DATA;
                endcase
            end
            S_RD, S_LV_RD: begin
                avm_chipselect = 1'b1;
                avm_address    = A_DATA;
            end
            S_EC_RD: begin
                avm_chipselect = 1'b1;
                avm_address    = A_EDGE;
            end
            S_EC_CAP: begin
                // Any write to the edge register clears every captured bit.
                if (avm_readdata != '0) begin
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_address    = A_EDGE;
                    avm_writedata  = '1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_currctrl_gpio_master.sv
// Directed bench for currctrl_gpio_master (POLL_DIV = 8) with a behavioural
// GPIO slave: data/out_port, falling-edge capture, set/clear registers.
// Outputs are sampled and inputs driven on the falling clock edge.

module tb_currctrl_gpio_master;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op   = 2'd0;
    logic [W-1:0] cmd_data = '0;
    logic         rsp_valid;
    logic [W-1:0] rsp_data;
    logic         evt_valid;
    logic [W-1:0] evt_mask;
    logic [W-1:0] evt_level;
    logic         busy;
    logic [2:0]   avm_address;
    logic         avm_chipselect;
    logic         avm_write_n;
    logic [W-1:0] avm_writedata;
    logic [W-1:0] avm_readdata = '0;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    currctrl_gpio_master #(.POLL_DIV(8), .DATA_W(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .evt_valid      (evt_valid),
        .evt_mask       (evt_mask),
        .evt_level      (evt_level),
        .busy           (busy),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata)
    );

    // ---------------- GPIO slave model ----------------
    logic [W-1:0] in_port  = '0;
    logic [W-1:0] out_port = '0;
    logic [W-1:0] ec_reg   = '0;
    logic [W-1:0] prev_in  = '0;

    always @(posedge clk) begin
        prev_in <= in_port;
        if (avm_chipselect && !avm_write_n) begin
            case (avm_address)
                3'd0:    out_port <= avm_writedata;
                3'd4:    out_port <= out_port | avm_writedata;
                3'd5:    out_port <= out_port & ~avm_writedata;
                default: ;
            endcase
        end
        if (avm_chipselect && !avm_write_n && avm_address == 3'd3)
            ec_reg <= prev_in & ~in_port;
        else
            ec_reg <= ec_reg | (prev_in & ~in_port);
        if (avm_chipselect && avm_write_n)
            avm_readdata <= (avm_address == 3'd0) ? in_port :
                            (avm_address == 3'd3) ? ec_reg : '0;
        else
            avm_readdata <= '0;
    end

    // ---------------- driver tasks ----------------
    // Advance to the next edge-capture read cycle (EC_RD), bounded.
    task automatic sync_poll(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(avm_chipselect && avm_write_n && avm_address == 3'd3) && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 40) begin
            miscompares++;
            $display("FAIL %s_poll_sync: got no edge-capture read in 40 cycles, expected one", name);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit early;
        repeat (3) @(negedge clk);
        vectors++;
        if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b0, 1'b1, 3'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_bus: got cs=%b wn=%b a=%0d wd=%h, expected cs=0 wn=1 a=0 wd=0",
                     avm_chipselect, avm_write_n, avm_address, avm_writedata);
        end
        vectors++;
        if ({cmd_ready, rsp_valid, evt_valid, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got rdy/rsp/evt/busy=%b, expected 0000",
                     {cmd_ready, rsp_valid, evt_valid, busy});
        end
        vectors++;
        if ({rsp_data, evt_mask, evt_level} !== 96'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h %h, expected zeros", rsp_data, evt_mask, evt_level);
        end
        reset = 1'b0;
        early = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8 && avm_chipselect) early = 1'b1;
            if (k == 6) begin
                vectors++;
                if (cmd_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL reset_ready_c6: got %b, expected 1", cmd_ready);
                end
            end
            if (k == 7) begin
                vectors++;
                if (cmd_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_pend_c7: got cmd_ready %b, expected 0", cmd_ready);
                end
            end
        end
        vectors++;
        if (early) begin
            miscompares++;
            $display("FAIL reset_early_cs: got chipselect before cycle 8, expected none");
        end
        vectors++;
        if ({avm_chipselect, avm_write_n, avm_address} !== {1'b1, 1'b1, 3'd3}) begin
            miscompares++;
            $display("FAIL reset_first_poll: got cs=%b wn=%b a=%0d, expected 1 1 3",
                     avm_chipselect, avm_write_n, avm_address);
        end
    endtask

    task automatic test_writes();
        logic [2:0]   exp_a [3];
        logic [W-1:0] exp_d [3];
        exp_a[0] = 3'd0; exp_d[0] = 32'hA5A5A5A5;
        exp_a[1] = 3'd4; exp_d[1] = 32'h0000000F;
        exp_a[2] = 3'd5; exp_d[2] = 32'h000000A0;
        sync_poll("writes");
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (cmd_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL wr%0d_ready: got %b, expected 1", i, cmd_ready);
            end
            cmd_valid = 1'b1;
            cmd_op    = 2'(i);
            cmd_data  = exp_d[i];
            @(negedge clk);
            vectors++;
            if ({avm_chipselect, avm_write_n, avm_address, avm_writedata, cmd_ready} !==
                {1'b1, 1'b0, exp_a[i], exp_d[i], 1'b0}) begin
                miscompares++;
                $display("FAIL wr%0d_bus: got cs=%b wn=%b a=%0d wd=%h rdy=%b, expected 1 0 %0d %h 0",
                         i, avm_chipselect, avm_write_n, avm_address, avm_writedata, cmd_ready,
                         exp_a[i], exp_d[i]);
            end
            if (i == 2) cmd_valid = 1'b0;
            else begin
                cmd_op   = 2'(i + 1);
                cmd_data = exp_d[i + 1];
                @(negedge clk);
            end
        end
        @(negedge clk);
        vectors++;
        if (out_port !== 32'hA5A5A50F) begin
            miscompares++;
            $display("FAIL wr_out_port: got %h, expected a5a5a50f", out_port);
        end
    endtask

    task automatic test_read();
        in_port = 32'h12345678;
        sync_poll("read");
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_data  = 32'hDEADBEEF;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_ready: got %b, expected 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        vectors++;
        if ({avm_chipselect, avm_write_n, avm_address, rsp_valid, busy} !== {1'b1, 1'b1, 3'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rd_addr: got cs=%b wn=%b a=%0d rsp=%b busy=%b, expected 1 1 0 0 1",
                     avm_chipselect, avm_write_n, avm_address, rsp_valid, busy);
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_data} !== {1'b1, 32'h12345678}) begin
            miscompares++;
            $display("FAIL rd_rsp: got valid=%b data=%h, expected 1 12345678", rsp_valid, rsp_data);
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_data, cmd_ready} !== {1'b0, 32'h12345678, 1'b1}) begin
            miscompares++;
            $display("FAIL rd_after: got valid=%b data=%h rdy=%b, expected 0 12345678 1",
                     rsp_valid, rsp_data, cmd_ready);
        end
    endtask

    task automatic run_event_poll(input logic [W-1:0] m, input logic [W-1:0] l, input string name);
        sync_poll(name);
        @(negedge clk);
        vectors++;
        if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b1, 1'b0, 3'd3, 32'hFFFFFFFF}) begin
            miscompares++;
            $display("FAIL %s_clear: got cs=%b wn=%b a=%0d wd=%h, expected 1 0 3 ffffffff",
                     name, avm_chipselect, avm_write_n, avm_address, avm_writedata);
        end
        @(negedge clk);
        vectors++;
        if ({avm_chipselect, avm_write_n, avm_address, evt_valid} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL %s_lv_rd: got cs=%b wn=%b a=%0d evt=%b, expected 1 1 0 0",
                     name, avm_chipselect, avm_write_n, avm_address, evt_valid);
        end
        @(negedge clk);
        vectors++;
        if ({evt_valid, evt_mask, evt_level} !== {1'b1, m, l}) begin
            miscompares++;
            $display("FAIL %s_evt: got v=%b mask=%h level=%h, expected 1 %h %h",
                     name, evt_valid, evt_mask, evt_level, m, l);
        end
        @(negedge clk);
        vectors++;
        if ({evt_valid, busy, evt_mask, evt_level} !== {1'b0, 1'b0, m, l}) begin
            miscompares++;
            $display("FAIL %s_after: got v=%b busy=%b mask=%h level=%h, expected 0 0 %h %h",
                     name, evt_valid, busy, evt_mask, evt_level, m, l);
        end
    endtask

    task automatic test_event();
        // 0x12345678 -> 0x8 drops every bit but bit 3.
        in_port = 32'h00000008;
        run_event_poll(32'h12345670, 32'h00000008, "evt_bulk");
        in_port = 32'h00000000;
        @(negedge clk);
        in_port = 32'h00000F00;
        run_event_poll(32'h00000008, 32'h00000F00, "evt_bit3");
    endtask

    task automatic test_no_event();
        sync_poll("noevt");
        @(negedge clk);
        vectors++;
        if ({avm_chipselect, evt_valid, busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL noevt_cap: got cs/evt/busy=%b, expected 001", {avm_chipselect, evt_valid, busy});
        end
        @(negedge clk);
        vectors++;
        if ({busy, evt_valid, cmd_ready, evt_mask} !== {3'b001, 32'h00000008}) begin
            miscompares++;
            $display("FAIL noevt_idle: got busy/evt/rdy=%b mask=%h, expected 001 00000008",
                     {busy, evt_valid, cmd_ready}, evt_mask);
        end
    endtask

    task automatic test_collision();
        bit rdy_seen;
        sync_poll("coll");
        repeat (6) @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL coll_ready_pre: got %b, expected 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_data  = '0;
        rdy_seen  = cmd_ready;
        @(negedge clk);
        vectors++;
        if ({avm_chipselect, avm_write_n, avm_address} !== {1'b1, 1'b1, 3'd3}) begin
            miscompares++;
            $display("FAIL coll_poll_first: got cs=%b wn=%b a=%0d, expected 1 1 3",
                     avm_chipselect, avm_write_n, avm_address);
        end
        rdy_seen = rdy_seen | cmd_ready;
        @(negedge clk);
        rdy_seen = rdy_seen | cmd_ready;
        vectors++;
        if (rdy_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_ready_low: got cmd_ready high during poll, expected low");
        end
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL coll_ready_after: got %b, expected 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        vectors++;
        if ({avm_chipselect, avm_write_n, avm_address} !== {1'b1, 1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL coll_rd_addr: got cs=%b wn=%b a=%0d, expected 1 1 0",
                     avm_chipselect, avm_write_n, avm_address);
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_data} !== {1'b1, 32'h00000F00}) begin
            miscompares++;
            $display("FAIL coll_rsp: got v=%b data=%h, expected 1 00000f00", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_reset_mid_poll();
        bit flag;
        in_port = 32'h00000000;
        sync_poll("rstpoll");
        @(negedge clk);
        vectors++;
        if ({avm_chipselect, avm_write_n, avm_address} !== {1'b1, 1'b0, 3'd3}) begin
            miscompares++;
            $display("FAIL rstpoll_clear: got cs=%b wn=%b a=%0d, expected 1 0 3",
                     avm_chipselect, avm_write_n, avm_address);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({avm_chipselect, avm_write_n, avm_address, avm_writedata, busy} !== {1'b0, 1'b1, 3'd0, 32'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL rstpoll_async_idle: got cs=%b wn=%b a=%0d wd=%h busy=%b, expected 0 1 0 0 0",
                     avm_chipselect, avm_write_n, avm_address, avm_writedata, busy);
        end
        flag = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (evt_valid || rsp_valid || avm_chipselect) flag = 1'b1;
        end
        vectors++;
        if (flag || evt_mask !== '0 || rsp_data !== '0) begin
            miscompares++;
            $display("FAIL rstpoll_held: got pulse=%b mask=%h rsp=%h, expected 0 0 0", flag, evt_mask, rsp_data);
        end
        reset = 1'b0;
        flag = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8 && (avm_chipselect || evt_valid)) flag = 1'b1;
        end
        vectors++;
        if (flag || {avm_chipselect, avm_write_n, avm_address} !== {1'b1, 1'b1, 3'd3}) begin
            miscompares++;
            $display("FAIL rstpoll_restart: got early=%b cs=%b wn=%b a=%0d at cycle 8, expected 0 1 1 3",
                     flag, avm_chipselect, avm_write_n, avm_address);
        end
        // The interrupted clear never reached the slave, so the capture is still there.
        repeat (3) @(negedge clk);
        vectors++;
        if ({evt_valid, evt_mask, evt_level} !== {1'b1, 32'h00000F00, 32'h00000000}) begin
            miscompares++;
            $display("FAIL rstpoll_evt: got v=%b mask=%h level=%h, expected 1 00000f00 00000000",
                     evt_valid, evt_mask, evt_level);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_writes();
        test_read();
        test_event();
        test_no_event();
        test_collision();
        test_reset_mid_poll();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
